// File: rtl/calc_r_seq_pkg.sv
// Shared types and defaults for the calc_r column sequencer.
// Vector geometry, state encoding and timing defaults live here.
package calc_r_seq_pkg;

    localparam int I  = 20;
    localparam int Q  = 15;
    localparam int N  = 32;
    localparam int J  = 16;
    localparam int CW = $clog2(J + 1);

    localparam int BLANK_CYC_DEF = 2;
    localparam int TMO_CYC_DEF   = 256;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        ISSUE,
        BLANK,
        WAIT,
        DONE
    } seq_state_t;

    typedef logic [I-1:0][N-1:0] vec_t;

    function automatic logic [CW-1:0] clamp_cols(input logic [CW-1:0] n);
        return (n > CW'(J)) ? CW'(J) : n;
    endfunction

endpackage

// File: rtl/calc_r_seq.sv
// Column sequencer feeding one calc_r unit: r <- r -/+ A[:,j]*x_hat[j].
// Build with ZERO_SKIP_EN defined to bypass columns whose x_hat is +/-0.
module calc_r_seq
    import calc_r_seq_pkg::*;
#(
    parameter int BLANK_CYC = BLANK_CYC_DEF,
    parameter int TMO_CYC   = TMO_CYC_DEF
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          go,
    input  logic          op,
    input  logic [CW-1:0] num_cols,
    input  vec_t          r_init,
    output logic [CW-1:0] x_addr,
    input  logic [N-1:0]  x_data,
    output logic [CW-1:0] col_idx,
    output logic          cr_start,
    output logic          cr_op,
    output logic [N-1:0]  cr_x_hat,
    output vec_t          cr_r,
    input  vec_t          cr_nxt_r,
    input  logic          cr_ready,
    output vec_t          r_out,
    output logic          busy,
    output logic          done,
    output logic          tmo_err
);

    localparam int CMAX = (TMO_CYC > BLANK_CYC) ? TMO_CYC : BLANK_CYC;
    localparam int CNTW = $clog2(CMAX + 1);

    seq_state_t    state_q, state_d;
    logic          op_q, op_d;
    logic [CW-1:0] ncols_q, ncols_d;
    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] cidx_q, cidx_d;
    logic [CNTW-1:0] cnt_q, cnt_d;
    logic          tmo_q, tmo_d;
    logic [N-1:0]  xhat_q, xhat_d;
    vec_t          racc_q, racc_d;
    vec_t          rout_q, rout_d;

    logic          skip;
    logic          last;
    logic [CW-1:0] ncols_in;

`ifdef ZERO_SKIP_EN
    assign skip = (x_data[N-2:0] == '0);
`else
    assign skip = 1'b0;
`endif

    assign last     = ((col_q + CW'(1)) == ncols_q);
    assign ncols_in = clamp_cols(num_cols);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            op_q    <= 1'b0;
            ncols_q <= '0;
            col_q   <= '0;
            cidx_q  <= '0;
            cnt_q   <= '0;
            tmo_q   <= 1'b0;
            xhat_q  <= '0;
            racc_q  <= '0;
            rout_q  <= '0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            ncols_q <= ncols_d;
            col_q   <= col_d;
            cidx_q  <= cidx_d;
            cnt_q   <= cnt_d;
            tmo_q   <= tmo_d;
            xhat_q  <= xhat_d;
            racc_q  <= racc_d;
            rout_q  <= rout_d;
        end
    end

    always_comb begin
        state_d = state_q;
        op_d    = op_q;
        ncols_d = ncols_q;
        col_d   = col_q;
        cidx_d  = cidx_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        xhat_d  = xhat_q;
        racc_d  = racc_q;
        rout_d  = rout_q;
        unique case (state_q)
            IDLE: begin
                if (go) begin
                    op_d    = op;
                    ncols_d = ncols_in;
                    racc_d  = r_init;
                    tmo_d   = 1'b0;
                    col_d   = '0;
                    state_d = (ncols_in == '0) ? DONE : FETCH;
                end
            end
            FETCH: begin
                cidx_d  = col_q;
                state_d = ISSUE;
            end
            ISSUE: begin
                if (skip) begin
                    col_d   = col_q + CW'(1);
                    state_d = last ? DONE : FETCH;
                end else begin
                    xhat_d  = x_data;
                    cnt_d   = CNTW'(BLANK_CYC - 1);
                    state_d = BLANK;
                end
            end
            // calc_r may still show ready from the previous column here
            BLANK: begin
                if (cnt_q == '0) begin
                    state_d = WAIT;
                end else begin
                    cnt_d = cnt_q - CNTW'(1);
                end
            end
            WAIT: begin
                if (cr_ready) begin
                    racc_d  = cr_nxt_r;
                    col_d   = col_q + CW'(1);
                    state_d = last ? DONE : FETCH;
                end else if (cnt_q == CNTW'(TMO_CYC - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    cnt_d = cnt_q + CNTW'(1);
                end
            end
            DONE: begin
                rout_d  = racc_q;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        x_addr   = col_q;
        col_idx  = cidx_q;
        cr_start = (state_q == ISSUE) && !skip;
        cr_op    = op_q;
        cr_x_hat = xhat_q;
        cr_r     = racc_q;
        r_out    = rout_q;
        busy     = (state_q != IDLE);
        done     = (state_q == DONE);
        tmo_err  = tmo_q;
    end

endmodule

// File: tb/tb_calc_r_seq.sv
// Bench for calc_r_seq: behavioural calc_r and x memory around the DUT.
// Expected columns and residuals are queued at go and compared at done.
module tb_calc_r_seq;
    import calc_r_seq_pkg::*;

    localparam int TMO = 8;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          go;
    logic          op;
    logic [CW-1:0] num_cols;
    vec_t          r_init;
    logic [CW-1:0] x_addr;
    logic [N-1:0]  x_data;
    logic [CW-1:0] col_idx;
    logic          cr_start;
    logic          cr_op;
    logic [N-1:0]  cr_x_hat;
    vec_t          cr_r;
    vec_t          cr_nxt_r;
    logic          cr_ready;
    vec_t          r_out;
    logic          busy;
    logic          done;
    logic          tmo_err;

    always #5 clk = ~clk;

    calc_r_seq #(.BLANK_CYC(2), .TMO_CYC(TMO)) dut (
        .clk(clk), .rst_n(rst_n), .go(go), .op(op),
        .num_cols(num_cols), .r_init(r_init),
        .x_addr(x_addr), .x_data(x_data), .col_idx(col_idx),
        .cr_start(cr_start), .cr_op(cr_op), .cr_x_hat(cr_x_hat),
        .cr_r(cr_r), .cr_nxt_r(cr_nxt_r), .cr_ready(cr_ready),
        .r_out(r_out), .busy(busy), .done(done), .tmo_err(tmo_err)
    );

    logic [N-1:0] xmem [0:31];
    logic [N-1:0] amat [0:31][I];

    always @(posedge clk) x_data <= xmem[x_addr];

    function automatic longint sm2i(input logic [N-1:0] v);
        longint m;
        m = longint'(v[N-2:0]);
        return v[N-1] ? -m : m;
    endfunction

    function automatic logic [N-1:0] i2sm(input longint v);
        longint m;
        m = (v < 0) ? -v : v;
        return {v < 0, m[N-2:0]};
    endfunction

    // behavioural calc_r: result 3 cycles after start, optional stale ready
    logic pend, rdy_new, stuck;
    int   age, stale_hold;
    vec_t nxt_q;

    assign cr_ready = !stuck && (rdy_new || (pend && age < stale_hold));
    assign cr_nxt_r = nxt_q;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend    <= 1'b0;
            rdy_new <= 1'b0;
            age     <= 0;
            nxt_q   <= '0;
        end else if (cr_start) begin
            pend    <= 1'b1;
            age     <= 0;
            rdy_new <= 1'b0;
        end else if (pend) begin
            age <= age + 1;
            if (age == 2) begin
                for (int i = 0; i < I; i++) begin
                    longint p;
                    p = (sm2i(amat[col_idx][i]) * sm2i(cr_x_hat)) >>> Q;
                    nxt_q[i] <= i2sm(cr_op ? sm2i(cr_r[i]) + p
                                           : sm2i(cr_r[i]) - p);
                end
                rdy_new <= 1'b1;
                pend    <= 1'b0;
            end
        end
    end

    int   checks = 0;
    int   errors = 0;
    int   exp_col_q[$];
    int   obs_col_q[$];
    vec_t exp_rout_q[$];
    vec_t obs_rout;
    vec_t ev;
    logic obs_tmo, obs_busy, obs_done_after, got_done;
    int   ncyc;

    task automatic set_col(input int j, input logic [N-1:0] a,
                           input logic [N-1:0] x);
        for (int i = 0; i < I; i++) amat[j][i] = a;
        xmem[j] = x;
    endtask

    function automatic vec_t fill(input logic [N-1:0] v);
        vec_t r;
        for (int i = 0; i < I; i++) r[i] = v;
        return r;
    endfunction

    task automatic push_expect(input int nc, input logic o, input vec_t ri);
        longint acc[I];
        vec_t   e;
        int     n;
        bit     skip;
        n = (nc > J) ? J : nc;
        for (int i = 0; i < I; i++) acc[i] = sm2i(ri[i]);
        for (int j = 0; j < n; j++) begin
            skip = 1'b0;
`ifdef ZERO_SKIP_EN
            skip = (xmem[j][N-2:0] == '0);
`endif
            if (!skip) begin
                exp_col_q.push_back(j);
                for (int i = 0; i < I; i++) begin
                    longint p;
                    p = (sm2i(amat[j][i]) * sm2i(xmem[j])) >>> Q;
                    acc[i] = o ? acc[i] + p : acc[i] - p;
                end
            end
        end
        for (int i = 0; i < I; i++) e[i] = i2sm(acc[i]);
        exp_rout_q.push_back(e);
    endtask

    task automatic run_job(input int nc, input logic o, input vec_t ri);
        got_done = 1'b0;
        ncyc = -1;
        obs_busy = 1'b0;
        @(negedge clk);
        go = 1'b1;
        op = o;
        num_cols = CW'(nc);
        r_init = ri;
        @(negedge clk);
        go = 1'b0;
        for (int c = 0; c < 2000; c++) begin
            if (cr_start) obs_col_q.push_back(int'(col_idx));
            if (done) begin
                got_done = 1'b1;
                ncyc = c;
                obs_busy = busy;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        obs_rout = r_out;
        obs_tmo = tmo_err;
        obs_done_after = done;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        go = 1'b0;
        op = 1'b0;
        num_cols = '0;
        r_init = '0;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy, done, cr_start, tmo_err, cr_op} !== 5'b0) begin
            errors++;
            $display("FAIL reset_ctl: got %b want 00000",
                     {busy, done, cr_start, tmo_err, cr_op});
        end
        checks++;
        if (r_out !== '0 || cr_r !== '0) begin
            errors++;
            $display("FAIL reset_vec: r_out %h cr_r %h want 0", r_out, cr_r);
        end
        checks++;
        if ({x_addr, col_idx, cr_x_hat} !== '0) begin
            errors++;
            $display("FAIL reset_idx: x_addr %0d col_idx %0d x_hat %h want 0",
                     x_addr, col_idx, cr_x_hat);
        end
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_single;
        set_col(0, 32'h0000_8000, 32'h0000_4000);
        push_expect(1, 1'b0, fill(32'h0001_0000));
        run_job(1, 1'b0, fill(32'h0001_0000));
        checks++;
        if (!got_done || ncyc != 6) begin
            errors++;
            $display("FAIL single_lat: done %b cycles %0d want 1/6",
                     got_done, ncyc);
        end
        checks++;
        if (obs_col_q.size() != exp_col_q.size()) begin
            errors++;
            $display("FAIL single_starts: got %0d want %0d",
                     obs_col_q.size(), exp_col_q.size());
        end
        ev = exp_rout_q.pop_front();
        checks++;
        if (obs_rout !== ev || obs_rout[7] !== 32'h0000_C000) begin
            errors++;
            $display("FAIL single_rout: got %h want %h", obs_rout, ev);
        end
        checks++;
        if (obs_done_after !== 1'b0 || obs_busy !== 1'b1) begin
            errors++;
            $display("FAIL single_pulse: done_after %b busy %b want 0/1",
                     obs_done_after, obs_busy);
        end
        exp_col_q.delete();
        obs_col_q.delete();
    endtask

    task automatic test_multi;
        for (int j = 0; j < 3; j++) set_col(j, 32'h0000_8000, 32'h0000_8000);
        push_expect(3, 1'b1, '0);
        run_job(3, 1'b1, '0);
        checks++;
        if (!got_done || obs_col_q.size() != 3) begin
            errors++;
            $display("FAIL multi_starts: done %b got %0d want 3",
                     got_done, obs_col_q.size());
        end
        while (exp_col_q.size() > 0 && obs_col_q.size() > 0) begin
            int e, o;
            e = exp_col_q.pop_front();
            o = obs_col_q.pop_front();
            checks++;
            if (o != e) begin
                errors++;
                $display("FAIL multi_col: got %0d want %0d", o, e);
            end
        end
        ev = exp_rout_q.pop_front();
        checks++;
        if (obs_rout !== ev || obs_rout[0] !== 32'h0001_8000) begin
            errors++;
            $display("FAIL multi_rout: got %h want %h", obs_rout, ev);
        end
        exp_col_q.delete();
        obs_col_q.delete();
    endtask

    task automatic test_stale_ready;
        stale_hold = 2;
        set_col(0, 32'h0000_8000, 32'h0000_4000);
        push_expect(1, 1'b0, fill(32'h0001_0000));
        run_job(1, 1'b0, fill(32'h0001_0000));
        ev = exp_rout_q.pop_front();
        checks++;
        if (!got_done || obs_rout !== ev) begin
            errors++;
            $display("FAIL stale_rout: got %h want %h", obs_rout, ev);
        end
        checks++;
        if (obs_col_q.size() != 1) begin
            errors++;
            $display("FAIL stale_starts: got %0d want 1", obs_col_q.size());
        end
        stale_hold = 0;
        exp_col_q.delete();
        obs_col_q.delete();
    endtask

    task automatic test_zero_cols;
        vec_t ri;
        for (int i = 0; i < I; i++) ri[i] = i2sm(longint'(i * 1000 - 7000));
        push_expect(0, 1'b0, ri);
        @(negedge clk);
        go = 1'b1;
        num_cols = '0;
        r_init = ri;
        @(negedge clk);
        checks++;
        if (done !== 1'b1 || busy !== 1'b1 || cr_start !== 1'b0) begin
            errors++;
            $display("FAIL zero_done: done %b busy %b start %b want 1/1/0",
                     done, busy, cr_start);
        end
        @(negedge clk);
        go = 1'b0;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL go_in_done: busy %b done %b want 0/0", busy, done);
        end
        ev = exp_rout_q.pop_front();
        checks++;
        if (r_out !== ev || exp_col_q.size() != 0) begin
            errors++;
            $display("FAIL zero_rout: got %h want %h", r_out, ev);
        end
        @(negedge clk);
    endtask

    task automatic test_timeout;
        vec_t ri;
        ri = fill(32'h8000_3000);
        stuck = 1'b1;
        run_job(2, 1'b0, ri);
        checks++;
        if (!got_done || ncyc != 4 + TMO) begin
            errors++;
            $display("FAIL tmo_lat: done %b cycles %0d want 1/%0d",
                     got_done, ncyc, 4 + TMO);
        end
        checks++;
        if (obs_tmo !== 1'b1 || obs_rout !== ri) begin
            errors++;
            $display("FAIL tmo_flag: tmo %b r_out %h want 1 %h",
                     obs_tmo, obs_rout, ri);
        end
        checks++;
        if (obs_col_q.size() != 1) begin
            errors++;
            $display("FAIL tmo_starts: got %0d want 1", obs_col_q.size());
        end
        obs_col_q.delete();
        stuck = 1'b0;
        push_expect(0, 1'b0, '0);
        run_job(0, 1'b0, '0);
        ev = exp_rout_q.pop_front();
        checks++;
        if (obs_tmo !== 1'b0 || obs_rout !== ev) begin
            errors++;
            $display("FAIL tmo_clear: tmo %b r_out %h want 0 %h",
                     obs_tmo, obs_rout, ev);
        end
        exp_col_q.delete();
        obs_col_q.delete();
    endtask

    task automatic test_clamp;
        vec_t ri;
        for (int j = 0; j < J; j++) begin
            xmem[j] = {1'($urandom_range(1)), 31'($urandom_range(32768, 1))};
            for (int i = 0; i < I; i++)
                amat[j][i] = {1'($urandom_range(1)),
                              31'($urandom_range(65536, 1))};
        end
        for (int i = 0; i < I; i++)
            ri[i] = {1'($urandom_range(1)), 31'($urandom_range(200000))};
        push_expect(20, 1'b0, ri);
        run_job(20, 1'b0, ri);
        checks++;
        if (!got_done || obs_col_q.size() != exp_col_q.size()) begin
            errors++;
            $display("FAIL clamp_starts: done %b got %0d want %0d",
                     got_done, obs_col_q.size(), exp_col_q.size());
        end
        while (exp_col_q.size() > 0 && obs_col_q.size() > 0) begin
            int e, o;
            e = exp_col_q.pop_front();
            o = obs_col_q.pop_front();
            checks++;
            if (o != e) begin
                errors++;
                $display("FAIL clamp_col: got %0d want %0d", o, e);
            end
        end
        ev = exp_rout_q.pop_front();
        checks++;
        if (obs_rout !== ev) begin
            errors++;
            $display("FAIL clamp_rout: got %h want %h", obs_rout, ev);
        end
        exp_col_q.delete();
        obs_col_q.delete();
    endtask

    task automatic test_zero_skip;
        int want;
        set_col(0, 32'h0000_8000, 32'h0000_0000);
        set_col(1, 32'h0001_0000, 32'h8000_0000);
        set_col(2, 32'h0000_8000, 32'h0000_4000);
`ifdef ZERO_SKIP_EN
        want = 1;
`else
        want = 3;
`endif
        push_expect(3, 1'b0, fill(32'h0001_0000));
        run_job(3, 1'b0, fill(32'h0001_0000));
        checks++;
        if (!got_done || obs_col_q.size() != want) begin
            errors++;
            $display("FAIL skip_starts: done %b got %0d want %0d",
                     got_done, obs_col_q.size(), want);
        end
        while (exp_col_q.size() > 0 && obs_col_q.size() > 0) begin
            int e, o;
            e = exp_col_q.pop_front();
            o = obs_col_q.pop_front();
            checks++;
            if (o != e) begin
                errors++;
                $display("FAIL skip_col: got %0d want %0d", o, e);
            end
        end
        ev = exp_rout_q.pop_front();
        checks++;
        if (obs_rout !== ev || obs_rout[3] !== 32'h0000_C000) begin
            errors++;
            $display("FAIL skip_rout: got %h want %h", obs_rout, ev);
        end
        exp_col_q.delete();
        obs_col_q.delete();
    endtask

    task automatic test_reset_mid_run;
        bit seen;
        stuck = 1'b1;
        set_col(0, 32'h0000_8000, 32'h0000_4000);
        @(negedge clk);
        go = 1'b1;
        num_cols = CW'(1);
        r_init = fill(32'h0001_0000);
        @(negedge clk);
        go = 1'b0;
        repeat (4) @(negedge clk);
        checks++;
        if (busy !== 1'b1 || cr_start !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_wait: busy %b start %b done %b want 1/0/0",
                     busy, cr_start, done);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done, cr_start, tmo_err} !== 4'b0 || r_out !== '0 ||
            cr_r !== '0 || col_idx !== '0 || cr_x_hat !== '0) begin
            errors++;
            $display("FAIL mid_reset: ctl %b r_out %h cr_r %h want 0",
                     {busy, done, cr_start, tmo_err}, r_out, cr_r);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stuck = 1'b0;
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (done || cr_start) seen = 1'b1;
        end
        checks++;
        if (seen) begin
            errors++;
            $display("FAIL mid_nodone: activity after reset got 1 want 0");
        end
    endtask

    initial begin
        stuck = 1'b0;
        stale_hold = 0;
        for (int j = 0; j < 32; j++) set_col(j, '0, '0);
        test_reset();
        test_single();
        test_multi();
        test_stale_ready();
        test_zero_cols();
        test_timeout();
        test_clamp();
        test_zero_skip();
        test_reset_mid_run();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
